memory_stage: RTL and testbench

Memory stage of the sequential Y86-64 processor, directly downstream of `execute`. It takes `icode`, `valE`, `valA` and `valP` for the current instruction and performs the single data-memory access. It holds a byte-addressed, little-endian data memory and returns `valM` to writeback. It also produces the processor status code, latches stop conditions, and zero-fills memory after reset.

---
 rtl/memory_stage.sv | 181 ++++++++++++++++++
 tb/tb_memory_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 sequential memory stage.
// Holds a byte-addressed little-endian data memory, performs the single data
// access of the current instruction, produces the processor status code,
// latches stop conditions and zero-fills the memory after every reset.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        dmem_error,
  output logic        ready,
  output logic        halted
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int CW    = AW - 3;
  localparam int WORDS = MEM_BYTES / 8;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   counter_r;
  logic [2:0]      stop_code_r;
  logic [7:0]      mem_r [MEM_BYTES];

  logic            rd_s;
  logic            wr_s;
  logic            use_vala_s;
  logic [63:0]     addr_s;
  logic [63:0]     wdata_s;
  logic            access_err_s;
  logic [AW-1:0]   idx_s;
  logic [AW-1:0]   clr_base_s;
  logic [63:0]     rdata_s;
  logic [2:0]      run_stat_s;

  // Decode the access kind, address source and store data from icode.
  always_comb begin
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    use_vala_s = 1'b0;
    wdata_s    = 64'd0;
    case (icode)
      4'h4: begin wr_s = 1'b1; wdata_s = valA; end
      4'h5: begin rd_s = 1'b1; end
      4'h8: begin wr_s = 1'b1; wdata_s = valP; end
      4'h9: begin rd_s = 1'b1; use_vala_s = 1'b1; end
      4'hA: begin wr_s = 1'b1; wdata_s = valA; end
      4'hB: begin rd_s = 1'b1; use_vala_s = 1'b1; end
      default: begin rd_s = 1'b0; wr_s = 1'b0; end
    endcase
    if (use_vala_s) begin
      addr_s = valA;
    end else begin
      addr_s = valE;
    end
    // Full 64-bit compare so a huge address can never alias into the array.
    access_err_s = (rd_s || wr_s) && (addr_s > MAX_ADDR);
    // A faulting address is never used to index; park it at 0.
    if (access_err_s) begin
      idx_s = '0;
    end else begin
      idx_s = addr_s[AW-1:0];
    end
    clr_base_s = {counter_r, 3'b000};
  end

  // Combinational little-endian read of the eight bytes at idx_s.
  always_comb begin
    rdata_s = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rdata_s[8*i +: 8] = mem_r[idx_s + AW'(i)];
    end
  end

  // Status priority: fetch fault, illegal instruction, data fault, halt.
  always_comb begin
    if (imem_error) begin
      run_stat_s = STAT_ADR;
    end else if (!instr_valid) begin
      run_stat_s = STAT_INS;
    end else if (access_err_s) begin
      run_stat_s = STAT_ADR;
    end else if (icode == 4'h0) begin
      run_stat_s = STAT_HLT;
    end else begin
      run_stat_s = STAT_AOK;
    end
  end

  // Output selection by state; only RUN exposes the live access results.
  always_comb begin
    valM       = 64'd0;
    stat       = STAT_AOK;
    dmem_error = 1'b0;
    ready      = 1'b0;
    halted     = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        ready = 1'b0;
      end
      ST_RUN: begin
        if (rd_s && !access_err_s) begin
          valM = rdata_s;
        end else begin
          valM = 64'd0;
        end
        stat       = run_stat_s;
        dmem_error = access_err_s;
        ready      = 1'b1;
      end
      ST_STOP: begin
        stat   = stop_code_r;
        ready  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // State machine, memory clearing, write commit and stop-code latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      counter_r   <= '0;
      stop_code_r <= STAT_AOK;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          for (int i = 0; i < 8; i++) begin
            mem_r[clr_base_s + AW'(i)] <= 8'h00;
          end
          counter_r <= counter_r + CW'(1);
          if (counter_r == LAST_WORD) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_stat_s != STAT_AOK) begin
            // Faulting or halting instruction never commits its own write.
            state_r     <= ST_STOP;
            stop_code_r <= run_stat_s;
          end else if (wr_s) begin
            for (int i = 0; i < 8; i++) begin
              mem_r[idx_s + AW'(i)] <= wdata_s[8*i +: 8];
            end
          end
        end
        ST_STOP: begin
          state_r <= ST_STOP;
        end
        default: begin
          state_r   <= ST_CLEAR;
          counter_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed bench for memory_stage with a per-cycle reference model.
module tb_memory_stage;

  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [63:0] valE = 64'd0;
  logic [63:0] valA = 64'd0;
  logic [63:0] valP = 64'd0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        dmem_error;
  logic        ready;
  logic        halted;

  int total = 0;
  int bad = 0;

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .valM(valM), .stat(stat), .dmem_error(dmem_error), .ready(ready), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [MB];
  int         m_clear_left = 0;
  bit         m_stopped = 1'b0;
  int         m_code = 1;
  bit         armed = 1'b0;

  function automatic bit is_read(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
  endfunction

  function automatic bit is_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  function automatic logic [63:0] m_addr(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    return (ic == 4'h9 || ic == 4'hB) ? a : e;
  endfunction

  function automatic bit m_err(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    logic [63:0] ad;
    ad = m_addr(ic, e, a);
    return (is_read(ic) || is_write(ic)) && (ad > 64'(MB - 8));
  endfunction

  function automatic int m_stat(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                                input logic iv, input logic ime);
    if (ime) return 3;
    if (!iv) return 4;
    if (m_err(ic, e, a)) return 3;
    if (ic == 4'h0) return 2;
    return 1;
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] ad);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 7; k >= 0; k--) v = (v << 8) | 64'(m_mem[int'(ad) + k]);
    return v;
  endfunction

  // Advance the model on each rising edge using the inputs held over the cycle.
  always @(posedge clk) begin
    if (rst) begin
      armed        <= 1'b1;
      m_clear_left <= MB / 8;
      m_stopped    <= 1'b0;
      m_code       <= 1;
      for (int k = 0; k < MB; k++) m_mem[k] <= 8'h00;
    end else if (armed) begin
      if (m_clear_left > 0) begin
        m_clear_left <= m_clear_left - 1;
      end else if (!m_stopped) begin
        if (m_stat(icode, valE, valA, instr_valid, imem_error) != 1) begin
          m_stopped <= 1'b1;
          m_code    <= m_stat(icode, valE, valA, instr_valid, imem_error);
        end else if (is_write(icode)) begin
          for (int k = 0; k < 8; k++)
            m_mem[int'(m_addr(icode, valE, valA)) + k] <=
              8'(((icode == 4'h8) ? valP : valA) >> (8 * k));
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic [63:0] ev;
    int          es;
    bit          ee, er, eh;
    if (armed) begin
      ev = 64'd0; es = 1; ee = 1'b0; er = 1'b0; eh = 1'b0;
      if (m_clear_left > 0) begin
        er = 1'b0;
      end else if (m_stopped) begin
        es = m_code; er = 1'b1; eh = 1'b1;
      end else begin
        er = 1'b1;
        ee = m_err(icode, valE, valA);
        es = m_stat(icode, valE, valA, instr_valid, imem_error);
        if (is_read(icode) && !ee) ev = m_read(m_addr(icode, valE, valA));
      end
      check("model_valM", valM, ev);
      check("model_stat", 64'(stat), 64'(es));
      check("model_dmem_error", 64'(dmem_error), 64'(ee));
      check("model_ready", 64'(ready), 64'(er));
      check("model_halted", 64'(halted), 64'(eh));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts edges after reset until ready; expected clear length is MB/8.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(MB / 8));
  endtask

  task automatic apply(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic iv, input logic ime);
    icode = ic; valE = e; valA = a; valP = p; instr_valid = iv; imem_error = ime;
    #2;
  endtask

  task automatic idle();
    apply(4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
  endtask

  initial begin
    idle();
    // Initialisation and reset state.
    do_reset();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
    wait_ready("clear_len");
    apply(4'h5, 64'h20, 64'd0, 64'd0, 1'b1, 1'b0);
    check("init_read", valM, 64'd0);
    tick();

    // Reset pulsed mid-clear restarts the full clear.
    idle();
    do_reset();
    tick(); tick(); tick();
    do_reset();
    wait_ready("clear_len_restart");

    // Store/load alignment.
    apply(4'h4, 64'h10, 64'h1122334455667788, 64'd0, 1'b1, 1'b0);
    tick();
    apply(4'h5, 64'h10, 64'd0, 64'd0, 1'b1, 1'b0);
    check("load_aligned", valM, 64'h1122334455667788);
    tick();
    apply(4'h5, 64'h13, 64'd0, 64'd0, 1'b1, 1'b0);
    check("load_unaligned", valM, 64'h0000001122334455);
    tick();

    // Stack ops.
    apply(4'h8, 64'h38, 64'd0, 64'h2A, 1'b1, 1'b0);
    tick();
    apply(4'h9, 64'd0, 64'h38, 64'd0, 1'b1, 1'b0);
    check("ret_valM", valM, 64'h2A);
    tick();
    apply(4'hB, 64'd0, 64'h38, 64'd0, 1'b1, 1'b0);
    check("pop_last_word_ok", 64'(dmem_error), 64'd0);
    tick();
    apply(4'hA, 64'h39, 64'h55, 64'd0, 1'b1, 1'b0);
    check("push_err", 64'(dmem_error), 64'd1);
    check("push_stat", 64'(stat), 64'd3);
    tick();
    idle();
    check("push_halted", 64'(halted), 64'd1);
    check("push_stop_code", 64'(stat), 64'd3);
    tick();

    // Halt: write something first so the re-clear after reset is observable.
    do_reset();
    wait_ready("clear_len_halt");
    apply(4'h4, 64'h20, 64'hDEADBEEF, 64'd0, 1'b1, 1'b0);
    tick();
    apply(4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    check("halt_stat", 64'(stat), 64'd2);
    tick();
    apply(4'h4, 64'd0, 64'hFF, 64'd0, 1'b1, 1'b0);
    check("halt_stays", 64'(stat), 64'd2);
    check("halt_halted", 64'(halted), 64'd1);
    tick();
    idle();
    do_reset();
    wait_ready("clear_len_after_halt");
    apply(4'h5, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    check("halt_no_commit", valM, 64'd0);
    tick();
    apply(4'h5, 64'h20, 64'd0, 64'd0, 1'b1, 1'b0);
    check("reclear", valM, 64'd0);
    tick();

    // Non-memory icode with a huge valE never faults; then address wrap.
    apply(4'h6, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1, 1'b0);
    check("alu_no_err", 64'(dmem_error), 64'd0);
    tick();
    apply(4'h5, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1, 1'b0);
    check("wrap_err", 64'(dmem_error), 64'd1);
    check("wrap_valM", valM, 64'd0);
    check("wrap_stat", 64'(stat), 64'd3);
    tick();

    // Priority.
    idle();
    do_reset();
    wait_ready("clear_len_prio");
    apply(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("prio_imem", 64'(stat), 64'd3);
    tick();
    idle();
    do_reset();
    wait_ready("clear_len_ins");
    apply(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    check("prio_ins", 64'(stat), 64'd4);
    tick();
    idle();
    check("ins_latched", 64'(stat), 64'd4);
    check("ins_halted", 64'(halted), 64'd1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
